// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencer for the 5-stage pipeline
//   (load-use stall, data-memory freeze, branch squash, stall counter)
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  localparam int               FC_W       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0]  FLUSH_LOAD = FC_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             ifid_flush_q, ifid_flush_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             hazard;
  logic [FC_W-1:0]  flush_dec;

  assign hazard = ex_memread && (ex_rd != '0) &&
                  ((id_use_rs && (id_rs == ex_rd)) ||
                   (id_use_rt && (id_rt == ex_rd)));

  assign flush_dec = (flush_cnt_q != '0) ? (flush_cnt_q - FC_W'(1)) : '0;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_bubble  = 1'b0;
    pipe_hold    = 1'b0;
    state_d      = ST_RUN;
    flush_cnt_d  = flush_cnt_q;
    ifid_flush_d = ifid_flush_q;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (dmem_busy) begin
      // Whole pipe frozen: flush progress is paused, not counted.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      state_d    = ST_MEMWAIT;
    end else if (br_taken) begin
      idex_bubble  = 1'b1;
      state_d      = ST_FLUSH;
      flush_cnt_d  = FLUSH_LOAD;
      ifid_flush_d = 1'b1;
    end else begin
      flush_cnt_d  = flush_dec;
      ifid_flush_d = (flush_dec != '0);
      if (hazard && (state_q != ST_LDSTALL)) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_d     = ST_LDSTALL;
      end else begin
        state_d = (flush_dec != '0) ? ST_FLUSH : ST_RUN;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      flush_cnt_q  <= '0;
      ifid_flush_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      ifid_flush_q <= ifid_flush_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ifid_flush = ifid_flush_q;
  assign state      = state_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : directed bench with a cycle model of the sequencer
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int FC    = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic             clk, rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_use_rs, id_use_rt, ex_memread, br_taken, dmem_busy;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
  logic [1:0]       state;
  logic [CW-1:0]    stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipe_hazard_ctrl #(.REG_W(REG_W), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .br_taken(br_taken), .dmem_busy(dmem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_hold(pipe_hold), .state(state), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: pipeline mode, remaining squash cycles, stall count.
  int m_mode = 0, m_left = 0, m_stall = 0;
  int n_mode = 0, n_left = 0, n_stall = 0;

  always @(negedge clk) begin : cmp
    int e_pc, e_ifw, e_bub, e_hold, nl;
    bit hz;
    if (rst) begin
      chk("rst_pc_write", pc_write, 0);
      chk("rst_ifid_write", ifid_write, 0);
      chk("rst_bubble", idex_bubble, 1);
      chk("rst_hold", pipe_hold, 0);
      chk("rst_flush", ifid_flush, 0);
      chk("rst_state", state, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      n_mode = 0; n_left = 0; n_stall = 0;
    end else begin
      hz = ex_memread && (ex_rd != 0) &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      nl = m_left;
      if (dmem_busy) begin
        e_pc = 0; e_ifw = 0; e_bub = 0; e_hold = 1; n_mode = 3;
      end else if (br_taken) begin
        e_pc = 1; e_ifw = 1; e_bub = 1; e_hold = 0; n_mode = 2; nl = FC;
      end else begin
        nl = (m_left > 0) ? m_left - 1 : 0;
        if (hz && m_mode != 1) begin
          e_pc = 0; e_ifw = 0; e_bub = 1; e_hold = 0; n_mode = 1;
        end else begin
          e_pc = 1; e_ifw = 1; e_bub = 0; e_hold = 0; n_mode = (nl > 0) ? 2 : 0;
        end
      end
      chk("pc_write", pc_write, e_pc);
      chk("ifid_write", ifid_write, e_ifw);
      chk("idex_bubble", idex_bubble, e_bub);
      chk("pipe_hold", pipe_hold, e_hold);
      chk("ifid_flush", ifid_flush, (m_left > 0) ? 1 : 0);
      chk("state", state, m_mode);
      chk("stall_cnt", stall_cnt, m_stall);
      n_left  = nl;
      n_stall = (e_pc == 0 && m_stall < CMAX) ? m_stall + 1 : m_stall;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_left = 0; m_stall = 0;
    end else begin
      m_mode = n_mode; m_left = n_left; m_stall = n_stall;
    end
  end

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 0; id_use_rt = 0; ex_memread = 0; br_taken = 0; dmem_busy = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic set_hazard();
    ex_memread = 1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1;
  endtask

  // {rs, rt, use_rs, use_rt, rd, memread}
  typedef struct { int rs; int rt; bit urs; bit urt; int rd; bit mr; } hz_vec_t;
  hz_vec_t tbl[6];

  initial begin
    tbl[0] = '{rs: 1, rt: 7,  urs: 1, urt: 1, rd: 7,  mr: 1};
    tbl[1] = '{rs: 9, rt: 2,  urs: 0, urt: 1, rd: 9,  mr: 1};
    tbl[2] = '{rs: 4, rt: 4,  urs: 1, urt: 1, rd: 4,  mr: 0};
    tbl[3] = '{rs: 3, rt: 6,  urs: 1, urt: 1, rd: 8,  mr: 1};
    tbl[4] = '{rs: 31, rt: 31, urs: 1, urt: 1, rd: 31, mr: 1};
    tbl[5] = '{rs: 2, rt: 12, urs: 1, urt: 0, rd: 12, mr: 1};

    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_pc_write", pc_write, 0);
    chk("reset_bubble", idex_bubble, 1);
    step();
    rst = 1'b0;

    // T1 load-use
    set_hazard();
    @(negedge clk);
    chk("t1_c0_pc_write", pc_write, 0);
    chk("t1_c0_ifid_write", ifid_write, 0);
    chk("t1_c0_bubble", idex_bubble, 1);
    step();
    @(negedge clk);
    chk("t1_c1_state", state, 1);
    chk("t1_c1_pc_write", pc_write, 1);
    chk("t1_c1_bubble", idex_bubble, 0);
    chk("t1_c1_stall_cnt", stall_cnt, 1);
    step();
    clear_inputs();

    // T2 r0 never hazards
    do_reset();
    ex_memread = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    step();
    step();
    @(negedge clk);
    chk("t2_pc_write", pc_write, 1);
    chk("t2_stall_cnt", stall_cnt, 0);
    clear_inputs();

    // Detection pattern table
    foreach (tbl[i]) begin
      step();
      id_rs = REG_W'(tbl[i].rs); id_rt = REG_W'(tbl[i].rt);
      id_use_rs = tbl[i].urs; id_use_rt = tbl[i].urt;
      ex_rd = REG_W'(tbl[i].rd); ex_memread = tbl[i].mr;
      step();
      clear_inputs();
    end

    // T3 branch squash length
    do_reset();
    br_taken = 1;
    @(negedge clk);
    chk("t3_br_bubble", idex_bubble, 1);
    chk("t3_br_flush_pre", ifid_flush, 0);
    step();
    br_taken = 0;
    @(negedge clk);
    chk("t3_flush_c1", ifid_flush, 1);
    chk("t3_state_c1", state, 2);
    step();
    @(negedge clk);
    chk("t3_flush_c2", ifid_flush, 1);
    step();
    @(negedge clk);
    chk("t3_flush_c3", ifid_flush, 0);
    chk("t3_state_c3", state, 0);

    // Branch while memory busy, flush held through a freeze, reload in FLUSH, hazard in FLUSH
    do_reset();
    br_taken = 1; dmem_busy = 1;
    step(); step();
    dmem_busy = 0;
    step();
    br_taken = 0;
    repeat (4) step();
    br_taken = 1;
    step();
    br_taken = 0; dmem_busy = 1;
    step(); step();
    dmem_busy = 0;
    repeat (4) step();
    br_taken = 1; step(); br_taken = 0; step();
    br_taken = 1; step(); br_taken = 0;
    repeat (3) step();
    br_taken = 1; step(); br_taken = 0;
    set_hazard();
    step(); step();
    clear_inputs();
    repeat (3) step();

    // T4 memory wait dominates a hazard
    do_reset();
    set_hazard();
    dmem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold", pipe_hold, 1);
      chk("t4_bubble", idex_bubble, 0);
      step();
    end
    dmem_busy = 0;
    @(negedge clk);
    chk("t4_state_memwait", state, 3);
    chk("t4_stall_cnt3", stall_cnt, 3);
    chk("t4_pc_write_haz", pc_write, 0);
    step();
    @(negedge clk);
    chk("t4_state_ldstall", state, 1);
    chk("t4_pc_write", pc_write, 1);
    chk("t4_stall_cnt4", stall_cnt, 4);
    step();
    clear_inputs();

    // T5 asynchronous reset in the middle of FLUSH
    do_reset();
    set_hazard();
    step();
    clear_inputs();
    br_taken = 1;
    step();
    br_taken = 0;
    @(negedge clk);
    chk("t5_flush_pre", ifid_flush, 1);
    chk("t5_stall_pre", stall_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_flush", ifid_flush, 0);
    chk("t5_async_state", state, 0);
    chk("t5_async_stall", stall_cnt, 0);
    chk("t5_async_pc_write", pc_write, 0);
    chk("t5_async_bubble", idex_bubble, 1);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_after_pc_write", pc_write, 1);
    chk("t5_after_state", state, 0);
    step(); step();

    // T6 counter saturation
    do_reset();
    set_hazard();
    dmem_busy = 1;
    repeat (14) step();
    @(negedge clk);
    chk("t6_stall14", stall_cnt, 14);
    step();
    @(negedge clk);
    chk("t6_stall15", stall_cnt, 15);
    repeat (6) step();
    @(negedge clk);
    chk("t6_stall_sat", stall_cnt, 15);
    step();
    clear_inputs();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
